// File: rtl/key_press_classifier_if.sv
// Signal bundle between a debounced key source and the key press classifier.
// The master drives the key level and enable; the slave returns the classified pulses and status.
interface key_press_classifier_if;
    logic       key_in;
    logic       enable;
    logic       short_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [1:0] state_out;

    modport master (
        output key_in,
        output enable,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held,
        input  state_out
    );

    modport slave (
        input  key_in,
        input  enable,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output held,
        output state_out
    );
endinterface

// File: rtl/key_press_classifier.sv
// Classifies one debounced key level into short-press, long-press and auto-repeat pulses.
// All timing is counted in clk cycles; every output comes straight from a flop.
module key_press_classifier #(
    parameter int MIN_TICKS    = 200,
    parameter int LONG_TICKS   = 10000,
    parameter int REPEAT_TICKS = 2000,
    parameter int CNT_W        = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    key_press_classifier_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESS   = 2'b01,
        HOLD    = 2'b10,
        LOCKOUT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             short_nx, long_nx, repeat_nx;
    logic             short_q, long_q, repeat_q, held_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nx  = state;
        cnt_nx    = cnt;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        repeat_nx = 1'b0;

        if (!bus.enable) begin
            state_nx = LOCKOUT;
            cnt_nx   = '0;
        end else begin
            case (state)
                LOCKOUT: begin
                    if (!bus.key_in) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                IDLE: begin
                    cnt_nx = '0;
                    if (bus.key_in) begin
                        state_nx = PRESS;
                        cnt_nx   = ONE;
                    end
                end
                PRESS: begin
                    if (bus.key_in) begin
                        // Comparing against LONG-1 keeps cnt from ever exceeding LONG_TICKS.
                        if (cnt >= LONG_LAST) begin
                            long_nx  = 1'b1;
                            state_nx = HOLD;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + ONE;
                        end
                    end else begin
                        short_nx = (cnt >= MIN_C);
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                HOLD: begin
                    if (bus.key_in) begin
                        if (cnt >= REP_LAST) begin
                            repeat_nx = 1'b1;
                            cnt_nx    = '0;
                        end else begin
                            cnt_nx = cnt + ONE;
                        end
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = LOCKOUT;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LOCKOUT;
            cnt      <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from pre-edge values.
            state    <= state_nx;
            cnt      <= cnt_nx;
            short_q  <= short_nx;
            long_q   <= long_nx;
            repeat_q <= repeat_nx;
            held_q   <= (state_nx == HOLD);
        end
    end

    assign bus.short_pulse  = short_q;
    assign bus.long_pulse   = long_q;
    assign bus.repeat_pulse = repeat_q;
    assign bus.held         = held_q;
    assign bus.state_out    = state;

endmodule
